// File: rtl/integral_image_builder_if.sv
// integral_image_builder_if: pixel stream in, integral-image memory writes and status out
interface integral_image_builder_if;
  logic        sof;
  logic        pix_valid;
  logic [3:0]  pix_data;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [19:0] wr_data;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  modport master (output sof, pix_valid, pix_data, input wr_en, wr_addr, wr_data, frame_done, busy, overrun);
  modport slave (input sof, pix_valid, pix_data, output wr_en, wr_addr, wr_data, frame_done, busy, overrun);
endinterface

// File: rtl/integral_image_builder.sv
// integral_image_builder: streaming 160x120 integral image; define II_DOWNSAMPLE_EN to accept 320x240 and keep even col/row only
module integral_image_builder (
  input logic clk_vga,
  input logic rst,
  integral_image_builder_if.slave bus
);
`ifdef II_DOWNSAMPLE_EN
  localparam int IW = 320;
  localparam int IH = 240;
`else
  localparam int IW = 160;
  localparam int IH = 120;
`endif
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t      state_q, state_d;
  logic [8:0]  col_q, col_d, col_b;
  logic [7:0]  row_q, row_d, row_b;
  logic [14:0] addr_q, addr_d, addr_b;
  logic [19:0] rs_q, rs_d, rs_b, rs_new, ii;
  logic [19:0] lb_q [160];
  logic [7:0]  x, y;
  logic        accept, acc, last, col_end;
  logic        wr_en_q, frame_done_q, overrun_q, overrun_d;
  logic [14:0] wr_addr_q;
  logic [19:0] wr_data_q;
  // sof restarts the position in the same cycle, so a coincident pixel lands at (0,0)
  always_comb begin
    accept    = bus.pix_valid && (bus.sof || state_q == ACTIVE);
    col_b     = bus.sof ? 9'd0 : col_q;
    row_b     = bus.sof ? 8'd0 : row_q;
    addr_b    = bus.sof ? 15'd0 : addr_q;
    rs_b      = bus.sof ? 20'd0 : rs_q;
`ifdef II_DOWNSAMPLE_EN
    acc       = accept && !col_b[0] && !row_b[0];
    x         = col_b[8:1];
    y         = {1'b0, row_b[7:1]};
`else
    acc       = accept;
    x         = col_b[7:0];
    y         = row_b;
`endif
    col_end   = col_b == 9'(IW - 1);
    last      = accept && col_end && row_b == 8'(IH - 1);
    rs_new    = (x != 8'd0 ? rs_b : 20'd0) + {16'd0, bus.pix_data};
    ii        = rs_new + (y != 8'd0 ? lb_q[x] : 20'd0);
    col_d     = accept ? (col_end ? 9'd0 : col_b + 9'd1) : col_b;
    row_d     = accept && col_end ? (row_b == 8'(IH - 1) ? 8'd0 : row_b + 8'd1) : row_b;
    addr_d    = acc ? addr_b + 15'd1 : addr_b;
    rs_d      = acc ? rs_new : rs_b;
    state_d   = last ? DONE : bus.sof ? ACTIVE : state_q == DONE ? IDLE : state_q;
    overrun_d = bus.sof ? 1'b0 : overrun_q | (bus.pix_valid && state_q != ACTIVE);
  end
  // state, counters and registered write port
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      rs_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      rs_q         <= rs_d;
      wr_en_q      <= acc;
      wr_addr_q    <= acc ? addr_b : wr_addr_q;
      wr_data_q    <= acc ? ii : wr_data_q;
      frame_done_q <= last;
      overrun_q    <= overrun_d;
    end
  end
  // line buffer of the previous row; never cleared because row 0 ignores it
  always_ff @(posedge clk_vga) begin
    if (acc && !rst) lb_q[x] <= ii;
  end
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_integral_image_builder.sv
// tb_integral_image_builder: directed frames against a closed-form integral-image expectation
module tb_integral_image_builder;
  logic clk_vga = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  integral_image_builder_if ifc ();
  integral_image_builder dut (.clk_vga(clk_vga), .rst(rst), .bus(ifc.slave));
  always #5 clk_vga = ~clk_vga;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic v, input logic [3:0] d);
    ifc.sof = s;
    ifc.pix_valid = v;
    ifc.pix_data = d;
    @(posedge clk_vga);
    @(negedge clk_vga);
  endtask
  task automatic run_frame(input int first, input int val, input int gap_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      while (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        cyc(1'b0, 1'b0, 4'd0);
        chk("gap_wr_en", 32'(ifc.wr_en), 32'd0);
      end
      cyc(i == 0, 1'b1, 4'(i == 0 ? first : val));
      chk("wr_en", 32'(ifc.wr_en), 32'd1);
      chk("wr_addr", 32'(ifc.wr_addr), 32'(i));
      chk("wr_data", 32'(ifc.wr_data), 32'(val * (i % 160 + 1) * (i / 160 + 1) + first - val));
      chk("frame_done", 32'(ifc.frame_done), 32'(i == 19199));
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(ifc.wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(ifc.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(ifc.wr_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(ifc.frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_overrun"}, 32'(ifc.overrun), 32'd0);
  endtask
  initial begin
    ifc.sof = 1'b0;
    ifc.pix_valid = 1'b0;
    ifc.pix_data = 4'd0;
    @(negedge clk_vga);
    cyc(1'b1, 1'b1, 4'd9);
    cyc(1'b0, 1'b0, 4'd0);
    chk_zero("reset");
    rst = 1'b0;
    cyc(1'b0, 1'b1, 4'd4);
    chk("idle_pix_no_write", 32'(ifc.wr_en), 32'd0);
    chk("idle_overrun", 32'(ifc.overrun), 32'd1);
    cyc(1'b1, 1'b0, 4'd0);
    chk("sof_clears_overrun", 32'(ifc.overrun), 32'd0);
    chk("sof_busy", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 4'd0);
    chk("pre_latency_wr_en", 32'(ifc.wr_en), 32'd0);
    run_frame(7, 1, 10, 19200);
    chk("busy_at_frame_done", 32'(ifc.busy), 32'd1);
    cyc(1'b0, 1'b1, 4'd9);
    chk("after_done_no_write", 32'(ifc.wr_en), 32'd0);
    chk("after_done_overrun", 32'(ifc.overrun), 32'd1);
    chk("after_done_busy", 32'(ifc.busy), 32'd0);
    chk("single_frame_done", 32'(ifc.frame_done), 32'd0);
    cyc(1'b0, 1'b0, 4'd0);
    chk("overrun_sticky", 32'(ifc.overrun), 32'd1);
    cyc(1'b1, 1'b0, 4'd0);
    chk("sof_clears_overrun2", 32'(ifc.overrun), 32'd0);
    run_frame(15, 15, 0, 19200);
    cyc(1'b0, 1'b0, 4'd0);
    chk("max_last_data_held", 32'(ifc.wr_data), 32'd288000);
    run_frame(1, 1, 0, 500);
    run_frame(3, 2, 0, 8000);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 4'd5);
    chk_zero("midframe_reset");
    rst = 1'b0;
    run_frame(1, 1, 30, 2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/integral_image_builder.md
INTEGRAL_IMAGE_BUILDER -- requirements
Module: integral_image_builder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-002 clk_vga  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sof  input  1  start-of-frame strobe, one cycle.
REQ-005 pix_valid  input  1  pix_data valid this cycle; there is no backpressure.
REQ-006 pix_data  input  4  grayscale pixel, unsigned, raster order.
REQ-007 wr_en  output  1  integral-image memory write strobe.
REQ-008 wr_addr  output  15  write address, equal to row*160 + col (0..19199).
REQ-009 wr_data  output  20  integral-image value, unsigned.
REQ-010 frame_done  output  1  one-cycle pulse, coincident with the write to address 19199.
REQ-011 busy  output  1  high from an accepted sof until the cycle after frame_done.
REQ-012 overrun  output  1  sticky flag: a pixel arrived while idle or after a frame completed; cleared by sof or rst.

Function
REQ-013 The block SHALL compute ii(x,y) = sum of pix_data over all pixels (i,j) with i<=x and j<=y, for a 160x120 frame.
REQ-014 Per-row state: a 20-bit row accumulator rs, and a line buffer of 160 x 20 bits holding ii of the previous row.
REQ-015 Accepted pixel at (x,y): rs_new = rs + pix_data when x>0, or pix_data when x==0; ii = rs_new + lb[x], with lb[x] taken as 0 when y==0; then lb[x] <= ii.
REQ-016 All sums SHALL be 20-bit unsigned with no saturation; the maximum value 19200*15 = 288000 fits.
REQ-017 Latency: a pixel accepted at cycle N SHALL produce wr_en=1 with its wr_addr and wr_data at cycle N+1; wr_en is otherwise 0.
REQ-018 Counters: col 0..159 and row 0..119; col wraps at 159 to 0 and increments row; addr increments by 1 per write.
REQ-019 State machine: IDLE -> (sof) ACTIVE -> (write of pixel 19199) DONE -> IDLE on the next cycle.
REQ-020 In IDLE or DONE, pix_valid without sof SHALL be ignored and SHALL set overrun.
REQ-021 sof while ACTIVE SHALL abort the frame: counters go to 0, rs goes to 0, and the new frame starts; no frame_done is issued for the aborted frame.
REQ-022 sof and pix_valid in the same cycle: the pixel SHALL be treated as (0,0) of the new frame.
REQ-023 pix_valid gaps of any length within a row or frame SHALL be tolerated with state held.
REQ-024 A pending write (N+1) from the last pixel of an aborted frame SHALL still be issued.

Reset
REQ-025 On rst the block SHALL go to IDLE, with wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, overrun=0, counters=0 and rs=0.
REQ-026 rst mid-frame SHALL drop the frame; the line buffer contents need not be cleared, because row 0 ignores lb.
REQ-027 rst SHALL have priority over sof and pix_valid.

Configuration
REQ-028 Macro II_DOWNSAMPLE_EN: when defined, the input SHALL be 320x240 and only pixels with even input column and even input row are accumulated; other valid pixels advance the input counters only.
REQ-029 With II_DOWNSAMPLE_EN, frame_done and the DONE state SHALL follow input pixel 76799 (the last 320x240 pixel); the write addresses remain 0..19199.
REQ-030 Without II_DOWNSAMPLE_EN, the input SHALL be 160x120 and every valid pixel is accumulated.

Verification
REQ-031 Constant image: sof, then 19200 pixels of value 1 back-to-back -> wr_data at address a = (row+1)*(col+1); address 19199 = 19200; frame_done pulses once.
REQ-032 Maximum value: all pixels = 15 -> address 19199 = 288000 and address 159 = 2400; no wraparound.
REQ-033 Latency and gaps: pixel (0,0)=7 accepted at cycle 10 -> wr_en at 11 with wr_addr=0 and wr_data=7; random pix_valid gaps -> the address sequence stays contiguous.
REQ-034 Abort: sof, 500 pixels, then sof+pix_valid (value 3) -> the next write has wr_addr=0 and wr_data=3; no frame_done for the first frame.
REQ-035 Overrun: a pixel after frame_done and before sof -> no write, overrun=1; the next sof clears it.
REQ-036 Reset: rst at pixel 8000 -> all outputs 0 the next cycle, busy=0; a fresh frame then yields correct values.
